// File: rtl/upl_pkg.sv
// Shared UPL bus definitions: word width, UDP/IP header layout and the
// port-filter state encoding.
package upl_pkg;

   localparam int UPL_W = 32;

   localparam int HDR_DST_IP = 0;
   localparam int HDR_SRC_IP = 1;
   localparam int HDR_PORTS  = 2;
   localparam int HDR_LEN    = 3;

   localparam int PORT_DST_HI = 31;
   localparam int PORT_DST_LO = 16;
   localparam int PORT_SRC_HI = 15;
   localparam int PORT_SRC_LO = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_REQ  = 2'd2;
   localparam logic [1:0] S_SEND = 2'd3;

   function automatic logic [15:0] dst_port(input logic [UPL_W-1:0] word);
      return word[PORT_DST_HI:PORT_DST_LO];
   endfunction

endpackage

// File: rtl/upl_if.sv
// UPL stream bus: request/acknowledge handshake plus a contiguous
// enable-qualified word burst per packet.
interface upl_if;
   import upl_pkg::*;

   logic             req;
   logic             enable;
   logic             ack;
   logic [UPL_W-1:0] data;

   modport master (output req, output enable, output data, input ack);
   modport slave  (input req, input enable, input data, output ack);

endinterface

// File: rtl/upl_pkt_buf.sv
// Simple dual-port packet RAM with a registered read port (1-cycle latency).
module upl_pkt_buf
   import upl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [UPL_W-1:0]      wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [UPL_W-1:0]      rdata
);

   logic [UPL_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/upl_udp_port_filter.sv
// Store-and-forward UDP destination-port filter: buffers a whole packet,
// forwards it as one unbroken burst on a port match, otherwise drops it.
module upl_udp_port_filter
   import upl_pkg::*;
#(
   parameter logic [15:0] MATCH_PORT = 16'h4000,
   parameter int          DEPTH_LOG2 = 4,
   parameter int          MIN_WORDS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   upl_if.slave        up,
   upl_if.master       dn,
   output logic [15:0] pass_cnt,
   output logic [15:0] drop_cnt
);

   localparam int                CNT_W = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(2 ** DEPTH_LOG2);

   logic [1:0]            state;
   logic [CNT_W-1:0]      wr_cnt;
   logic [CNT_W-1:0]      len;
   logic [CNT_W-1:0]      rd;
   logic                  mismatch;
   logic                  ovf;
   logic                  rd_vld;
   logic                  req_q;
   logic                  en_q;
   logic [UPL_W-1:0]      data_q;
   logic [UPL_W-1:0]      rdata;
   logic                  we;
   logic [DEPTH_LOG2-1:0] waddr;
   logic                  unused_req;

   // Packet start is marked by enable alone; the request line carries no extra information here.
   assign unused_req = up.req;
   assign up.ack     = (state == S_IDLE);
   assign dn.req     = req_q;
   assign dn.enable  = en_q;
   assign dn.data    = data_q;

   always_comb begin
      we    = 1'b0;
      waddr = wr_cnt[DEPTH_LOG2-1:0];
      if (state == S_IDLE && up.enable) begin
         we    = 1'b1;
         waddr = '0;
      end else if (state == S_RECV && up.enable && wr_cnt != FULL) begin
         we = 1'b1;
      end
   end

   upl_pkt_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (up.data),
      .raddr (rd[DEPTH_LOG2-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wr_cnt   <= '0;
         len      <= '0;
         rd       <= '0;
         mismatch <= 1'b0;
         ovf      <= 1'b0;
         rd_vld   <= 1'b0;
         req_q    <= 1'b0;
         en_q     <= 1'b0;
         data_q   <= '0;
         pass_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               en_q <= 1'b0;
               if (up.enable) begin
                  wr_cnt   <= CNT_W'(1);
                  mismatch <= 1'b0;
                  ovf      <= 1'b0;
                  state    <= S_RECV;
               end
            end
            S_RECV: begin
               if (up.enable) begin
                  if (wr_cnt == FULL) begin
                     ovf <= 1'b1;
                  end else begin
                     wr_cnt <= wr_cnt + CNT_W'(1);
                  end
                  if (wr_cnt == CNT_W'(HDR_PORTS) && dst_port(up.data) != MATCH_PORT) begin
                     mismatch <= 1'b1;
                  end
               end else if (mismatch || ovf || wr_cnt < CNT_W'(MIN_WORDS)) begin
                  if (drop_cnt != 16'hFFFF) begin
                     drop_cnt <= drop_cnt + 16'd1;
                  end
                  state <= S_IDLE;
               end else begin
                  len   <= wr_cnt;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (dn.ack) begin
                  req_q  <= 1'b0;
                  rd     <= '0;
                  rd_vld <= 1'b0;
                  state  <= S_SEND;
               end else begin
                  req_q <= 1'b1;
               end
            end
            S_SEND: begin
               // Reads run one cycle ahead of the output register, so the burst never stalls.
               if (rd < len) begin
                  rd     <= rd + CNT_W'(1);
                  rd_vld <= 1'b1;
               end else begin
                  rd_vld <= 1'b0;
               end
               en_q <= rd_vld;
               if (rd_vld) begin
                  data_q <= rdata;
               end
               if (rd_vld && rd == len) begin
                  if (pass_cnt != 16'hFFFF) begin
                     pass_cnt <= pass_cnt + 16'd1;
                  end
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_upl_udp_port_filter.sv
// Directed bench for the UDP port filter: forward, drop, runt, size
// boundaries, back-to-back packets and reset abort.
module tb_upl_udp_port_filter;
   import upl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pass_cnt;
   logic [15:0] drop_cnt;

   upl_if up_bus ();
   upl_if dn_bus ();

   upl_udp_port_filter dut (
      .clk      (clk),
      .rst      (rst),
      .up       (up_bus),
      .dn       (dn_bus),
      .pass_cnt (pass_cnt),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          ack_cyc = 0;
   int          first_en_cyc = 0;
   int          bursts = 0;
   int          ack_delay = 3;
   int          req_cycles = 0;
   bit          req_seen = 1'b0;
   bit          prev_en = 1'b0;
   logic [31:0] cap_q[$];
   logic [31:0] exp_q[$];

   // Downstream consumer: acknowledges after o_req has been high ack_delay cycles.
   initial begin
      dn_bus.ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            dn_bus.ack = 1'b0;
            req_cycles = 0;
         end else if (dn_bus.req && !dn_bus.ack) begin
            req_cycles++;
            if (req_cycles >= ack_delay) dn_bus.ack = 1'b1;
         end else begin
            dn_bus.ack = 1'b0;
            req_cycles = 0;
         end
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (dn_bus.ack === 1'b1) ack_cyc = cyc;
   end

   always @(negedge clk) begin
      if (dn_bus.enable === 1'b1) begin
         cap_q.push_back(dn_bus.data);
         if (!prev_en) begin
            bursts++;
            first_en_cyc = cyc;
         end
      end
      if (dn_bus.req === 1'b1) req_seen = 1'b1;
      prev_en = (dn_bus.enable === 1'b1);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] mkword(input logic [7:0] base, input int k, input logic [31:0] port_word);
      if (k == HDR_PORTS) return port_word;
      return {base, 16'h0000, 8'(k)};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      up_bus.req    = 1'b0;
      up_bus.enable = 1'b0;
      up_bus.data   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic clear_capture();
      cap_q.delete();
      exp_q.delete();
      bursts   = 0;
      req_seen = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [7:0] base, input logic [31:0] pw, input bit fwd);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         up_bus.req    = 1'b1;
         up_bus.enable = 1'b1;
         up_bus.data   = mkword(base, k, pw);
         if (fwd) exp_q.push_back(mkword(base, k, pw));
      end
      @(posedge clk);
      #1;
      up_bus.enable = 1'b0;
      up_bus.req    = 1'b0;
      up_bus.data   = '0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      up_bus.req    = 1'b0;
      up_bus.enable = 1'b0;
      up_bus.data   = '0;
      idle(2);
      total++; if (pass_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_pass: got %0d want 0", pass_cnt); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_drop: got %0d want 0", drop_cnt); end
      total++; if (dn_bus.req !== 1'b0) begin bad++; $display("[TB] FAIL rst_oreq: got %b want 0", dn_bus.req); end
      total++; if (dn_bus.enable !== 1'b0) begin bad++; $display("[TB] FAIL rst_oen: got %b want 0", dn_bus.enable); end
      total++; if (dn_bus.data !== 32'h0) begin bad++; $display("[TB] FAIL rst_odata: got %h want 0", dn_bus.data); end
      total++; if (up_bus.ack !== 1'b1) begin bad++; $display("[TB] FAIL rst_iack: got %b want 1", up_bus.ack); end
      rst = 1'b0;
   endtask

   task automatic test_match();
      do_reset();
      clear_capture();
      ack_delay = 3;
      send_pkt(6, 8'hA1, 32'h4000_1234, 1'b1);
      idle(30);
      total++; if (cap_q.size() !== 6) begin bad++; $display("[TB] FAIL match_len: got %0d want 6", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("[TB] FAIL match_word%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
      end
      total++; if (bursts !== 1) begin bad++; $display("[TB] FAIL match_bursts: got %0d want 1", bursts); end
      total++; if (first_en_cyc - ack_cyc !== 2) begin bad++; $display("[TB] FAIL match_latency: got %0d want 2", first_en_cyc - ack_cyc); end
      total++; if (pass_cnt !== 16'd1) begin bad++; $display("[TB] FAIL match_pass: got %0d want 1", pass_cnt); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL match_drop: got %0d want 0", drop_cnt); end
   endtask

   task automatic test_mismatch();
      do_reset();
      clear_capture();
      send_pkt(6, 8'hB2, 32'h4001_1234, 1'b0);
      total++; if (up_bus.ack !== 1'b0) begin bad++; $display("[TB] FAIL mis_iack_busy: got %b want 0", up_bus.ack); end
      idle(1);
      total++; if (up_bus.ack !== 1'b1) begin bad++; $display("[TB] FAIL mis_iack_end: got %b want 1", up_bus.ack); end
      idle(20);
      total++; if (req_seen !== 1'b0) begin bad++; $display("[TB] FAIL mis_oreq: got %b want 0", req_seen); end
      total++; if (cap_q.size() !== 0) begin bad++; $display("[TB] FAIL mis_words: got %0d want 0", cap_q.size()); end
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL mis_drop: got %0d want 1", drop_cnt); end
      total++; if (pass_cnt !== 16'd0) begin bad++; $display("[TB] FAIL mis_pass: got %0d want 0", pass_cnt); end
   endtask

   task automatic test_runt();
      do_reset();
      clear_capture();
      send_pkt(3, 8'hC3, 32'h4000_1234, 1'b0);
      idle(20);
      total++; if (req_seen !== 1'b0) begin bad++; $display("[TB] FAIL runt_oreq: got %b want 0", req_seen); end
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL runt_drop: got %0d want 1", drop_cnt); end
      total++; if (pass_cnt !== 16'd0) begin bad++; $display("[TB] FAIL runt_pass: got %0d want 0", pass_cnt); end
   endtask

   task automatic test_full_and_overflow();
      do_reset();
      clear_capture();
      ack_delay = 3;
      send_pkt(16, 8'hC4, 32'h4000_5678, 1'b1);
      idle(40);
      total++; if (cap_q.size() !== 16) begin bad++; $display("[TB] FAIL full_len: got %0d want 16", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("[TB] FAIL full_word%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
      end
      total++; if (bursts !== 1) begin bad++; $display("[TB] FAIL full_bursts: got %0d want 1", bursts); end
      total++; if (pass_cnt !== 16'd1) begin bad++; $display("[TB] FAIL full_pass: got %0d want 1", pass_cnt); end
      clear_capture();
      send_pkt(17, 8'hD5, 32'h4000_5678, 1'b0);
      idle(40);
      total++; if (req_seen !== 1'b0) begin bad++; $display("[TB] FAIL ovf_oreq: got %b want 0", req_seen); end
      total++; if (cap_q.size() !== 0) begin bad++; $display("[TB] FAIL ovf_words: got %0d want 0", cap_q.size()); end
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL ovf_drop: got %0d want 1", drop_cnt); end
      total++; if (pass_cnt !== 16'd1) begin bad++; $display("[TB] FAIL ovf_pass: got %0d want 1", pass_cnt); end
   endtask

   task automatic test_back_to_back();
      bit seen;
      do_reset();
      clear_capture();
      ack_delay = 3;
      send_pkt(6, 8'hE6, 32'h4000_0001, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (dn_bus.enable === 1'b1) seen = 1'b1;
         else idle(1);
      end
      total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL b2b_burst_start: got %b want 1", seen); end
      up_bus.req = 1'b1;
      total++; if (up_bus.ack !== 1'b0) begin bad++; $display("[TB] FAIL b2b_iack_busy: got %b want 0", up_bus.ack); end
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         idle(1);
         if (up_bus.ack === 1'b1) seen = 1'b1;
      end
      total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL b2b_iack_return: got %b want 1", seen); end
      send_pkt(6, 8'hF7, 32'h4000_0002, 1'b1);
      idle(30);
      total++; if (cap_q.size() !== 12) begin bad++; $display("[TB] FAIL b2b_len: got %0d want 12", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("[TB] FAIL b2b_word%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
      end
      total++; if (bursts !== 2) begin bad++; $display("[TB] FAIL b2b_bursts: got %0d want 2", bursts); end
      total++; if (pass_cnt !== 16'd2) begin bad++; $display("[TB] FAIL b2b_pass: got %0d want 2", pass_cnt); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL b2b_drop: got %0d want 0", drop_cnt); end
   endtask

   task automatic test_reset_abort();
      bit seen;
      do_reset();
      clear_capture();
      ack_delay = 1000;
      send_pkt(6, 8'h1A, 32'h4000_00AA, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         idle(1);
         if (dn_bus.req === 1'b1) seen = 1'b1;
      end
      total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL abort_oreq_up: got %b want 1", seen); end
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(2);
      total++; if (dn_bus.req !== 1'b0) begin bad++; $display("[TB] FAIL abort_oreq_clr: got %b want 0", dn_bus.req); end
      ack_delay = 3;
      send_pkt(6, 8'h2B, 32'h4000_00BB, 1'b1);
      idle(30);
      total++; if (cap_q.size() !== 6) begin bad++; $display("[TB] FAIL abort_len: got %0d want 6", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("[TB] FAIL abort_word%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
      end
      total++; if (pass_cnt !== 16'd1) begin bad++; $display("[TB] FAIL abort_pass: got %0d want 1", pass_cnt); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL abort_drop: got %0d want 0", drop_cnt); end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_runt();
      test_full_and_overflow();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
